// File: rtl/rf_pkg.sv
// Shared widths and types for the register-file writeback path.
package rf_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic {SRC_EX = 1'b0, SRC_LD = 1'b1} wb_src_e;
endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus issue-stage hazard check.
module rf_scoreboard
  import rf_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                sb_set,
  input  logic [ADDR_W-1:0]   sb_set_rd,
  input  logic                clr_valid,
  input  logic [ADDR_W-1:0]   clr_rd,
  input  logic                chk_valid,
  input  logic [ADDR_W-1:0]   chk_rs1,
  input  logic [ADDR_W-1:0]   chk_rs2,
  input  logic [ADDR_W-1:0]   chk_rd,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy_vec
);
  logic [NUM_REGS-1:0] busy_nxt;

  // Clear is applied before set so a new producer on the same register stays outstanding.
  always_comb begin
    busy_nxt = busy_vec;
    if (clr_valid) busy_nxt[clr_rd] = 1'b0;
    if (sb_set && (sb_set_rd != ZERO_REG)) busy_nxt[sb_set_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_vec <= '0;
    else     busy_vec <= busy_nxt;
  end

  // busy_vec[0] is never set, so x0 operands cannot stall.
  assign stall = chk_valid && (busy_vec[chk_rs1] || busy_vec[chk_rs2] || busy_vec[chk_rd]);
endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between EX and LD writeback,
// with a registered write bus and a pending-write scoreboard for issue hazards.
module rf_wb_arbiter
  import rf_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_valid,
  output logic                ex_ready,
  input  logic [ADDR_W-1:0]   ex_rd,
  input  logic [DATA_W-1:0]   ex_data,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [ADDR_W-1:0]   ld_rd,
  input  logic [DATA_W-1:0]   ld_data,
  output logic                rf_we,
  output logic [ADDR_W-1:0]   rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  input  logic                sb_set,
  input  logic [ADDR_W-1:0]   sb_set_rd,
  input  logic [ADDR_W-1:0]   chk_rs1,
  input  logic [ADDR_W-1:0]   chk_rs2,
  input  logic [ADDR_W-1:0]   chk_rd,
  input  logic                chk_valid,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy_vec
);
  // Handshake: a requester holds valid and payload until ready; ready is combinational,
  // never asserted without its valid, at most one side ready per cycle, and
  // valid && ready is the transfer.
  wb_src_e rr_ptr;
  logic    contended;
  wb_req_t acc;

  always_comb begin
    ex_ready  = 1'b0;
    ld_ready  = 1'b0;
    contended = ex_valid && ld_valid;
    if (contended) begin
      ex_ready = (rr_ptr == SRC_EX);
      ld_ready = (rr_ptr == SRC_LD);
    end else begin
      ex_ready = ex_valid;
      ld_ready = ld_valid;
    end
    acc.valid = ex_ready || ld_ready;
    acc.rd    = ld_ready ? ld_rd   : ex_rd;
    acc.data  = ld_ready ? ld_data : ex_data;
  end

  // The pointer only moves on a contended grant, so a lone requester never disturbs fairness.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= SRC_EX;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      if (contended) rr_ptr <= (rr_ptr == SRC_EX) ? SRC_LD : SRC_EX;
      rf_we <= acc.valid && (acc.rd != ZERO_REG);
      if (acc.valid && (acc.rd != ZERO_REG)) begin
        rf_waddr <= acc.rd;
        rf_wdata <= acc.data;
      end
    end
  end

  rf_scoreboard u_sb (
    .clk       (clk),
    .rst       (rst),
    .sb_set    (sb_set),
    .sb_set_rd (sb_set_rd),
    .clr_valid (acc.valid),
    .clr_rd    (acc.rd),
    .chk_valid (chk_valid),
    .chk_rs1   (chk_rs1),
    .chk_rs2   (chk_rs2),
    .chk_rd    (chk_rd),
    .stall     (stall),
    .busy_vec  (busy_vec)
  );
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter with a per-cycle reference model and literal spot checks.
module tb_rf_wb_arbiter;
  import rf_pkg::*;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                ex_valid = 1'b0, ld_valid = 1'b0;
  logic                ex_ready, ld_ready;
  logic [ADDR_W-1:0]   ex_rd = '0, ld_rd = '0;
  logic [DATA_W-1:0]   ex_data = '0, ld_data = '0;
  logic                rf_we;
  logic [ADDR_W-1:0]   rf_waddr;
  logic [DATA_W-1:0]   rf_wdata;
  logic                sb_set = 1'b0;
  logic [ADDR_W-1:0]   sb_set_rd = '0;
  logic [ADDR_W-1:0]   chk_rs1 = '0, chk_rs2 = '0, chk_rd = '0;
  logic                chk_valid = 1'b0;
  logic                stall;
  logic [NUM_REGS-1:0] busy_vec;

  int n_vec = 0;
  int n_err = 0;

  rf_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_data(ex_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .sb_set(sb_set), .sb_set_rd(sb_set_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd), .chk_valid(chk_valid),
    .stall(stall), .busy_vec(busy_vec)
  );

  // ---------------- clock/reset ----------------
  always #5 clk = ~clk;

  // Requester-side protocol: an unaccepted request must stay put.
  a_ex_hold: assert property (@(posedge clk) disable iff (rst)
    ex_valid && !ex_ready |=> ex_valid && $stable(ex_rd) && $stable(ex_data));
  a_ld_hold: assert property (@(posedge clk) disable iff (rst)
    ld_valid && !ld_ready |=> ld_valid && $stable(ld_rd) && $stable(ld_data));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit                         busy_m [NUM_REGS];
  int                         pref_m;    // 0: EX wins a tie, 1: LD wins a tie
  bit                         we_m;
  logic [ADDR_W+DATA_W-1:0]   exp_q[$];  // pending {waddr, wdata} for the write port

  // Who wins this cycle: -1 none, 0 EX, 1 LD.
  function automatic int winner();
    if (ex_valid && ld_valid) return pref_m;
    if (ex_valid) return 0;
    if (ld_valid) return 1;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      foreach (busy_m[r]) busy_m[r] = 1'b0;
      pref_m = 0;
      we_m   = 1'b0;
      exp_q.delete();
    end else begin
      int w;
      logic [ADDR_W-1:0] rd;
      logic [DATA_W-1:0] dt;
      w    = winner();
      we_m = 1'b0;
      if (w >= 0) begin
        rd = (w == 0) ? ex_rd : ld_rd;
        dt = (w == 0) ? ex_data : ld_data;
        busy_m[rd] = 1'b0;
        if (rd != 0) begin
          we_m = 1'b1;
          exp_q.push_back({rd, dt});
        end
        if (ex_valid && ld_valid) pref_m = 1 - pref_m;
      end
      if (sb_set && sb_set_rd != 0) busy_m[sb_set_rd] = 1'b1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!rst) begin
      int w;
      logic [NUM_REGS-1:0] bv;
      logic                st;
      logic [ADDR_W+DATA_W-1:0] e;
      w = winner();
      for (int r = 0; r < NUM_REGS; r++) bv[r] = busy_m[r];
      st = chk_valid && (busy_m[chk_rs1] || busy_m[chk_rs2] || busy_m[chk_rd]);
      check("m_ex_ready", 64'(ex_ready), 64'(w == 0));
      check("m_ld_ready", 64'(ld_ready), 64'(w == 1));
      check("m_busy_vec", 64'(busy_vec), 64'(bv));
      check("m_stall",    64'(stall),    64'(st));
      check("m_rf_we",    64'(rf_we),    64'(we_m));
      if (we_m && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("m_rf_waddr", 64'(rf_waddr), 64'(e[ADDR_W+DATA_W-1:DATA_W]));
        check("m_rf_wdata", 64'(rf_wdata), 64'(e[DATA_W-1:0]));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset and idle
    repeat (3) tick();
    rst = 1'b0;
    chk_valid = 1'b1; chk_rs1 = 5'd5; chk_rs2 = 5'd7; chk_rd = 5'd9;
    #2;
    check("rst_rf_we", 64'(rf_we), 64'd0);
    check("rst_busy",  64'(busy_vec), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    chk_valid = 1'b0;
    tick();

    // Single EX write
    sb_set = 1'b1; sb_set_rd = 5'd5;
    tick();
    sb_set = 1'b0;
    #2 check("ex_busy5_set", 64'(busy_vec[5]), 64'd1);
    ex_valid = 1'b1; ex_rd = 5'd5; ex_data = 32'hDEADBEEF;
    #1;
    check("ex_ready_single", 64'(ex_ready), 64'd1);
    check("ld_ready_single", 64'(ld_ready), 64'd0);
    tick();
    ex_valid = 1'b0;
    #2;
    check("ex_busy5_clr", 64'(busy_vec[5]), 64'd0);
    check("ex_rf_we",     64'(rf_we), 64'd1);
    check("ex_rf_waddr",  64'(rf_waddr), 64'd5);
    check("ex_rf_wdata",  64'(rf_wdata), 64'hDEADBEEF);
    tick();
    #2;
    check("idle_rf_we",    64'(rf_we), 64'd0);
    check("idle_rf_waddr", 64'(rf_waddr), 64'd5);
    tick();

    // Contention: grants alternate EX, LD, EX, LD
    ex_valid = 1'b1; ex_rd = 5'd3; ex_data = 32'h11;
    ld_valid = 1'b1; ld_rd = 5'd4; ld_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      #2;
      if (i > 0) check("cont_waddr", 64'(rf_waddr), (i % 2 == 1) ? 64'd3 : 64'd4);
      check("cont_ex_ready", 64'(ex_ready), 64'(i % 2 == 0));
      tick();
      if (i % 2 == 0) ex_data = ex_data + 32'h1;
      else            ld_data = ld_data + 32'h1;
    end
    ld_valid = 1'b0;
    #2;
    check("cont_waddr_last", 64'(rf_waddr), 64'd4);
    check("cont_wdata_last", 64'(rf_wdata), 64'h23);
    tick();
    ex_valid = 1'b0;
    tick();

    // x0 write and x0 scoreboard set
    ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'hFFFFFFFF;
    sb_set = 1'b1; sb_set_rd = 5'd0;
    #2 check("x0_ld_ready", 64'(ld_ready), 64'd1);
    tick();
    ld_valid = 1'b0; sb_set = 1'b0;
    #2;
    check("x0_rf_we", 64'(rf_we), 64'd0);
    check("x0_busy",  64'(busy_vec), 64'd0);
    tick();

    // Hazard stall released by an LD accept
    sb_set = 1'b1; sb_set_rd = 5'd7;
    tick();
    sb_set = 1'b0;
    chk_valid = 1'b1; chk_rs1 = 5'd0; chk_rs2 = 5'd7; chk_rd = 5'd0;
    #2 check("haz_stall", 64'(stall), 64'd1);
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h77;
    #1 check("haz_stall_accept", 64'(stall), 64'd1);
    tick();
    ld_valid = 1'b0;
    #2;
    check("haz_stall_clr", 64'(stall), 64'd0);
    check("haz_rf_waddr",  64'(rf_waddr), 64'd7);
    chk_valid = 1'b0;
    tick();

    // Set/clear collision on reg 9
    ex_valid = 1'b1; ex_rd = 5'd9; ex_data = 32'h99;
    sb_set = 1'b1; sb_set_rd = 5'd9;
    tick();
    ex_valid = 1'b0; sb_set = 1'b0;
    #2;
    check("coll_busy9",  64'(busy_vec[9]), 64'd1);
    check("coll_rf_we",  64'(rf_we), 64'd1);
    check("coll_waddr",  64'(rf_waddr), 64'd9);
    tick();

    // Lone grants must not move the pointer
    ex_valid = 1'b1; ex_rd = 5'd10; ex_data = 32'hA0;
    ld_valid = 1'b1; ld_rd = 5'd11; ld_data = 32'hB0;
    #2 check("ptr_first_ex", 64'(ex_ready), 64'd1);
    tick();
    ex_valid = 1'b0;
    tick();
    ld_valid = 1'b0;
    ex_valid = 1'b1; ex_rd = 5'd10; ex_data = 32'hA1;
    tick();
    ld_valid = 1'b1; ld_rd = 5'd11; ld_data = 32'hB1;
    ex_data = 32'hA2;
    #2 check("ptr_ld_pref", 64'(ld_ready), 64'd1);
    tick();
    ld_valid = 1'b0;
    tick();
    ex_valid = 1'b0;
    tick();

    // Asynchronous reset mid-cycle with a write on the bus
    ex_valid = 1'b1; ex_rd = 5'd12; ex_data = 32'hC;
    sb_set = 1'b1; sb_set_rd = 5'd12;
    tick();
    ex_valid = 1'b0; sb_set = 1'b0;
    chk_valid = 1'b1; chk_rs1 = 5'd9; chk_rs2 = 5'd12; chk_rd = 5'd0;
    #1 check("pre_rst_rf_we", 64'(rf_we), 64'd1);
    rst = 1'b1;
    #1;
    check("arst_rf_we",    64'(rf_we), 64'd0);
    check("arst_rf_waddr", 64'(rf_waddr), 64'd0);
    check("arst_rf_wdata", 64'(rf_wdata), 64'd0);
    check("arst_busy",     64'(busy_vec), 64'd0);
    check("arst_stall",    64'(stall), 64'd0);
    tick();
    rst = 1'b0;
    chk_valid = 1'b0;
    repeat (3) tick();

    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: the execute unit (EX, port 0) and the load/store unit return path (LD, port 1).
- Each requester uses a valid/ready handshake. Contention is resolved round-robin, and the granted write is registered onto the register-file write bus.
- Holds a per-register pending-write scoreboard that the issue stage queries to stall on RAW/WAW hazards.
- Sits between the execute/LSU writeback stage and the register file write port.

Parameters:
- DATA_W, 32, data width of the register file.
- ADDR_W, 5, register address width.
- NUM_REGS, 32, number of architectural registers; register 0 is hardwired zero.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ex_valid  in  1  EX writeback request.
- ex_ready  out  1  EX request accepted this cycle.
- ex_rd  in  ADDR_W  EX destination register.
- ex_data  in  DATA_W  EX result.
- ld_valid  in  1  LD writeback request.
- ld_ready  out  1  LD request accepted this cycle.
- ld_rd  in  ADDR_W  LD destination register.
- ld_data  in  DATA_W  LD result.
- rf_we  out  1  register file write enable.
- rf_waddr  out  ADDR_W  register file write address.
- rf_wdata  out  DATA_W  register file write data.
- sb_set  in  1  issue stage marks a destination register pending.
- sb_set_rd  in  ADDR_W  register to mark pending.
- chk_rs1  in  ADDR_W  issue-stage source 1 to check.
- chk_rs2  in  ADDR_W  issue-stage source 2 to check.
- chk_rd  in  ADDR_W  issue-stage destination to check.
- chk_valid  in  1  issue stage has an instruction to check.
- stall  out  1  hazard detected; issue must hold.
- busy_vec  out  NUM_REGS  scoreboard pending bits, for debug.

Behaviour:
- Reset, asynchronous, applied immediately: rf_we=0, rf_waddr=0, rf_wdata=0, busy_vec=0, round-robin pointer=EX-preferred, stall=0 (stall follows from busy_vec=0).
- Handshake:
  - ready is combinational from the valid inputs and the pointer. Exactly one of ex_ready/ld_ready may be 1 in a cycle, and ready is never asserted without the matching valid.
  - A transfer occurs when valid&&ready.
  - A requester must hold valid and its payload stable until ready; the bench checks this with an assertion.
- Arbitration:
  - Only one valid: grant it.
  - Both valid: grant the side the pointer prefers, then flip the pointer to the other side.
  - The pointer changes only on a contended grant.
  - No requester waits more than 1 cycle under continuous contention.
- Write port latency:
  - A transfer in cycle N gives rf_we=1 with the granted rd and data in cycle N+1, which the register file writes at the end of N+1.
  - With no transfer in cycle N, rf_we=0 in N+1; rf_waddr and rf_wdata keep their last values.
- x0 handling:
  - A request with rd=0 is still arbitrated and accepted, but rf_we stays 0.
  - sb_set with sb_set_rd=0 is ignored. busy_vec[0] is always 0.
- Scoreboard:
  - busy[r] is set at the clock edge when sb_set && sb_set_rd==r.
  - busy[r] is cleared at the clock edge when a transfer with rd==r is accepted, at acceptance time (cycle N), not at the N+1 write.
  - If set and clear hit the same r in the same cycle, set wins: the new producer is outstanding.
  - Writes to a register that is not busy are legal and leave the scoreboard unchanged.
- Stall (combinational):
  - stall = chk_valid && (busy[chk_rs1] || busy[chk_rs2] || busy[chk_rd]).
  - Address 0 never stalls.
- Forwarding: there is none. A consumer issues only after busy clears, which is the same cycle the producer is accepted. The register file read in cycle N+1 sees the old value, so issue logic must treat the first cycle after clear as requiring the rf_we/rf_waddr bypass. This block exports rf_we/rf_waddr/rf_wdata for that bypass.

Decomposition:
- Shared package rf_pkg holds:
  - constants DATA_W, ADDR_W, NUM_REGS and ZERO_REG=0;
  - typedef wb_req_t {valid, rd, data};
  - enum wb_src_e {SRC_EX, SRC_LD} for the round-robin pointer.
- One sub-module, rf_scoreboard: busy bit vector, set/clear logic and stall computation.
- Arbitration and the output register stay in rf_wb_arbiter.

Test Plan:
- Reset then idle: assert rst mid-cycle with rf_we=1 pending -> outputs go to 0 immediately; busy_vec=0, stall=0.
- Single EX write: sb_set rd=5, next cycle ex_valid rd=5 data=0xDEADBEEF -> ex_ready=1 same cycle; busy[5] clears that edge; next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
- Contention: ex_valid(rd=3, 0x11) and ld_valid(rd=4, 0x22) held together for 4 cycles with new payloads on each accept -> grants alternate EX, LD, EX, LD; rf_waddr sequence 3,4,3,4.
- x0 write: ld_valid rd=0 data=0xFFFFFFFF -> ld_ready=1, rf_we stays 0; sb_set rd=0 -> busy_vec stays 0.
- Hazard stall: busy[7] set, chk_valid=1, chk_rs2=7 -> stall=1; after ld accept with rd=7, stall=0 in the same cycle the busy bit clears.
- Set/clear collision: ex accept with rd=9 and sb_set rd=9 in the same cycle -> busy[9]=1 afterwards; rf_we=1 to reg 9 next cycle.
